// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Provides the bus widths (derived from the CPU's REG_LEN / DM_UNIT_MASK),
// the arbiter state encoding and the port identifier type.
package dmem_arbiter_pkg;

  localparam int unsigned REG_LEN      = 32;
  localparam int unsigned DM_UNIT_MASK = 255;

  localparam int unsigned ADDR_W = REG_LEN;
  localparam int unsigned DATA_W = DM_UNIT_MASK + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two cache-side requesters, the arbiter and
// Data_Memory.
//   p0_* : dcache request port        p1_* : ifetch refill request port
//   mem_*: Data_Memory enable/write/addr/data/ack handshake
//   rd_data_o : memory read data broadcast to both requesters
// Modport slave is the arbiter's view; master is the environment's view
// (requesters plus memory).
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W = dmem_arbiter_pkg::DATA_W
) ();

  logic              p0_enable_i;
  logic              p0_write_i;
  logic [ADDR_W-1:0] p0_addr_i;
  logic [DATA_W-1:0] p0_data_i;
  logic              p0_ack_o;

  logic              p1_enable_i;
  logic              p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_ack_o;

  logic [DATA_W-1:0] rd_data_o;

  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_data_i;

  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  mem_ack_i, mem_data_i,
    output p0_ack_o, p1_ack_o, rd_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output mem_ack_i, mem_data_i,
    input  p0_ack_o, p1_ack_o, rd_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-requester round-robin winner selection (purely combinational).
//   i_req0, i_req1 : request lines
//   i_last_grant   : port granted most recently
//   o_valid        : at least one request present
//   o_winner       : selected port (meaningful only when o_valid)
module rr_pick2
  import dmem_arbiter_pkg::*;
(
  input  logic     i_req0,
  input  logic     i_req1,
  input  port_id_t i_last_grant,
  output logic     o_valid,
  output port_id_t o_winner
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = PORT0;
    if (i_req0 && i_req1) begin
      o_winner = ~i_last_grant;
    end else if (i_req1) begin
      o_winner = PORT1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single Data_Memory port between the dcache
// (port 0) and the ifetch refill path (port 1). One line transaction at a
// time is captured into holding registers and replayed to memory; an
// optional watchdog aborts accesses that never acknowledge.
//   clk_i  : clock
//   rst_i  : asynchronous active-low reset
//   bus    : requester / memory handshake bundle (slave modport)
//   err_o  : sticky watchdog error flag
// Parameter TIMEOUT = 0 disables the watchdog.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = dmem_arbiter_pkg::ADDR_W,
  parameter int unsigned DATA_W  = dmem_arbiter_pkg::DATA_W,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus,
  output logic           err_o
);

  import dmem_arbiter_pkg::*;

  localparam logic        WD_EN    = (TIMEOUT != 0);
  localparam logic [31:0] WD_LIMIT = TIMEOUT - 32'd1;

  state_t            r_state;
  state_t            w_next_state;
  port_id_t          r_owner;
  port_id_t          r_last_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [31:0]       r_busy_cnt;
  logic              r_err;

  logic              w_valid;
  port_id_t          w_winner;
  logic              w_grant;
  logic              w_expire;

  rr_pick2 u_pick (
    .i_req0       (bus.p0_enable_i),
    .i_req1       (bus.p1_enable_i),
    .i_last_grant (r_last_grant),
    .o_valid      (w_valid),
    .o_winner     (w_winner)
  );

  // An ack in the expiry cycle takes priority, so expiry requires !ack.
  always_comb begin
    w_grant  = (r_state == ST_IDLE) && w_valid;
    w_expire = WD_EN && (r_state == ST_BUSY) && !bus.mem_ack_i &&
               (r_busy_cnt == WD_LIMIT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: if (w_valid) w_next_state = ST_BUSY;
      ST_BUSY: if (bus.mem_ack_i || w_expire) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_enable_o = (r_state == ST_BUSY);
    bus.mem_write_o  = r_write;
    bus.mem_addr_o   = r_addr;
    bus.mem_data_o   = r_data;
    bus.p0_ack_o     = bus.mem_ack_i && (r_state == ST_BUSY) &&
                       (r_owner == PORT0) && bus.p0_enable_i;
    bus.p1_ack_o     = bus.mem_ack_i && (r_state == ST_BUSY) &&
                       (r_owner == PORT1) && bus.p1_enable_i;
    bus.rd_data_o    = bus.mem_data_i;
    err_o            = r_err;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_owner      <= PORT0;
      r_last_grant <= PORT1;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_busy_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        r_busy_cnt   <= '0;
        if (w_winner == PORT1) begin
          r_write <= bus.p1_write_i;
          r_addr  <= bus.p1_addr_i;
          r_data  <= bus.p1_data_i;
        end else begin
          r_write <= bus.p0_write_i;
          r_addr  <= bus.p0_addr_i;
          r_data  <= bus.p0_data_i;
        end
      end else if ((r_state == ST_BUSY) && !bus.mem_ack_i) begin
        r_busy_cnt <= r_busy_cnt + 32'd1;
      end
      if (w_expire) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int unsigned TO = 16;

  logic clk_i = 1'b0;
  logic rst_n;
  logic err;

  always #5 clk_i = ~clk_i;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(256)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(256), .TIMEOUT(TO)) dut (
    .clk_i (clk_i),
    .rst_i (rst_n),
    .bus   (bus.slave),
    .err_o (err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory responder (environment, not a model) ----------
  int mem_lat  = 4;
  bit mem_hang = 1'b0;
  int en_cnt   = 0;

  always @(posedge clk_i) begin
    #1;
    if (!rst_n || !bus.mem_enable_o) begin
      en_cnt        = 0;
      bus.mem_ack_i = 1'b0;
    end else begin
      en_cnt++;
      bus.mem_ack_i = !mem_hang && (en_cnt == mem_lat);
    end
  end

  // ---------------- transaction-level reference model ---------------------
  bit           m_busy   = 1'b0;
  bit           m_owner  = 1'b0;
  bit           m_last   = 1'b1;
  logic         m_we     = 1'b0;
  logic [31:0]  m_addr   = '0;
  logic [255:0] m_data   = '0;
  int           m_age    = 0;
  bit           m_err    = 1'b0;

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1;
      m_we = 1'b0; m_addr = '0; m_data = '0; m_age = 0; m_err = 1'b0;
    end else if (!m_busy) begin
      if (bus.p0_enable_i || bus.p1_enable_i) begin
        if (bus.p0_enable_i && bus.p1_enable_i) m_owner = !m_last;
        else m_owner = bus.p1_enable_i;
        m_last = m_owner;
        m_we   = m_owner ? bus.p1_write_i : bus.p0_write_i;
        m_addr = m_owner ? bus.p1_addr_i  : bus.p0_addr_i;
        m_data = m_owner ? bus.p1_data_i  : bus.p0_data_i;
        m_busy = 1'b1;
        m_age  = 0;
      end
    end else begin
      m_age++;
      if (bus.mem_ack_i) begin
        m_busy = 1'b0;
      end else if (TO > 0 && m_age == int'(TO)) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge clk_i) begin
    chk1  ("cyc_mem_enable", bus.mem_enable_o, m_busy);
    chk1  ("cyc_mem_write",  bus.mem_write_o,  m_we);
    chk32 ("cyc_mem_addr",   bus.mem_addr_o,   m_addr);
    chk256("cyc_mem_data",   bus.mem_data_o,   m_data);
    chk1  ("cyc_p0_ack", bus.p0_ack_o,
           bus.mem_ack_i && m_busy && !m_owner && bus.p0_enable_i);
    chk1  ("cyc_p1_ack", bus.p1_ack_o,
           bus.mem_ack_i && m_busy && m_owner && bus.p1_enable_i);
    chk256("cyc_rd_data", bus.rd_data_o, bus.mem_data_i);
    chk1  ("cyc_err", err, m_err);
  end

  // ---------------- directed stimulus -------------------------------------
  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic await_ack(input bit port, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      #1;
      seen = port ? bus.p1_ack_o : bus.p0_ack_o;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL %s: ack got 0 expected 1 within 60 cycles", name);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [255:0] pat_a5;
  logic [255:0] pat_cafe;

  initial begin
    pat_a5   = {32{8'hA5}};
    pat_cafe = {16{16'hCAFE}};
    rst_n = 1'b0;
    bus.p0_enable_i = 1'b0; bus.p0_write_i = 1'b0; bus.p0_addr_i = '0; bus.p0_data_i = '0;
    bus.p1_enable_i = 1'b0; bus.p1_write_i = 1'b0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
    bus.mem_data_i = '0;
    step();
    step();
    #1;
    chk1 ("rst_mem_enable", bus.mem_enable_o, 1'b0);
    chk1 ("rst_err", err, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr_o, 32'h0);
    #1;
    rst_n = 1'b1;

    // Single read: enable high cycles 1..10, ack at 10, low at 11.
    mem_lat = 10;
    bus.mem_data_i = pat_a5;
    bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b0; bus.p0_addr_i = 32'h100;
    for (int c = 1; c <= 10; c++) begin
      step();
      #1;
      chk1("rd_enable", bus.mem_enable_o, 1'b1);
      chk1("rd_p0_ack", bus.p0_ack_o, (c == 10));
      if (c == 10) chk256("rd_data", bus.rd_data_o, pat_a5);
    end
    step();
    bus.p0_enable_i = 1'b0;
    #1;
    chk1("rd_enable_low", bus.mem_enable_o, 1'b0);

    // Tie after reset: p0 first, idle gap, p1; then a second tie goes to p0.
    reset_dut();
    mem_lat = 3;
    bus.p0_enable_i = 1'b1; bus.p0_addr_i = 32'h300;
    bus.p1_enable_i = 1'b1; bus.p1_addr_i = 32'h400; bus.p1_write_i = 1'b0;
    step();
    #1;
    chk32("tie_first_addr", bus.mem_addr_o, 32'h300);
    await_ack(1'b0, "tie_p0_ack");
    step();
    bus.p0_enable_i = 1'b0;
    #1;
    chk1("tie_gap", bus.mem_enable_o, 1'b0);
    step();
    #1;
    chk32("tie_second_addr", bus.mem_addr_o, 32'h400);
    bus.p0_enable_i = 1'b1; bus.p0_addr_i = 32'h500;
    await_ack(1'b1, "tie_p1_ack");
    step();
    bus.p1_addr_i = 32'h480;
    step();
    #1;
    chk32("rr_p0_next", bus.mem_addr_o, 32'h500);
    await_ack(1'b0, "rr_p0_ack");
    step();
    bus.p0_enable_i = 1'b0;
    step();
    #1;
    chk32("rr_p1_after", bus.mem_addr_o, 32'h480);
    await_ack(1'b1, "rr_p1_ack");
    step();
    bus.p1_enable_i = 1'b0;
    step();

    // Input change after grant: holding registers keep the granted values.
    mem_lat = 5;
    bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b1;
    bus.p1_addr_i = 32'h200; bus.p1_data_i = 256'h1234;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        bus.p1_addr_i = 32'hDEAD; bus.p1_data_i = 256'hBEEF; bus.p1_write_i = 1'b0;
      end
      #1;
      chk32 ("hold_addr",  bus.mem_addr_o,  32'h200);
      chk256("hold_data",  bus.mem_data_o,  256'h1234);
      chk1  ("hold_write", bus.mem_write_o, 1'b1);
      chk1  ("hold_p1_ack", bus.p1_ack_o, (c == 5));
    end
    step();
    bus.p1_enable_i = 1'b0;
    step();

    // Enable dropped mid-transaction: ack suppressed, p1 then served.
    mem_lat = 6;
    bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b0; bus.p0_addr_i = 32'h600;
    step();
    step();
    bus.p0_enable_i = 1'b0;
    bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h700;
    for (int c = 3; c <= 6; c++) begin
      step();
      #1;
      chk1("drop_enable", bus.mem_enable_o, 1'b1);
      chk1("drop_p0_ack", bus.p0_ack_o, 1'b0);
      chk1("drop_p1_ack", bus.p1_ack_o, 1'b0);
    end
    step();
    #1;
    chk1("drop_gap", bus.mem_enable_o, 1'b0);
    step();
    #1;
    chk32("drop_p1_addr", bus.mem_addr_o, 32'h700);
    await_ack(1'b1, "drop_p1_ack_final");
    step();
    bus.p1_enable_i = 1'b0;
    step();

    // Watchdog: 16 busy cycles without ack, then abort with sticky error.
    mem_hang = 1'b1;
    bus.p0_enable_i = 1'b1; bus.p0_addr_i = 32'h800;
    for (int c = 1; c <= 16; c++) begin
      step();
      #1;
      chk1("wd_enable", bus.mem_enable_o, 1'b1);
      chk1("wd_err_low", err, 1'b0);
    end
    step();
    #1;
    chk1("wd_enable_low", bus.mem_enable_o, 1'b0);
    chk1("wd_err_high", err, 1'b1);
    chk1("wd_no_ack", bus.p0_ack_o, 1'b0);
    bus.p0_enable_i = 1'b0;
    mem_hang = 1'b0;
    mem_lat = 2;
    step();
    bus.p1_enable_i = 1'b1; bus.p1_addr_i = 32'h900;
    await_ack(1'b1, "wd_after_p1_ack");
    chk1("wd_err_sticky", err, 1'b1);
    step();
    bus.p1_enable_i = 1'b0;
    step();

    // Reset mid-transaction, then an ack coinciding with watchdog expiry.
    mem_lat = 8;
    bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b1;
    bus.p0_addr_i = 32'hB00; bus.p0_data_i = 256'h55;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk1  ("mrst_enable", bus.mem_enable_o, 1'b0);
    chk32 ("mrst_addr",   bus.mem_addr_o,   32'h0);
    chk256("mrst_data",   bus.mem_data_o,   256'h0);
    chk1  ("mrst_write",  bus.mem_write_o,  1'b0);
    chk1  ("mrst_err",    err,              1'b0);
    chk1  ("mrst_p0_ack", bus.p0_ack_o,     1'b0);
    step();
    rst_n = 1'b1;
    bus.p0_enable_i = 1'b0;
    mem_lat = 16;
    bus.mem_data_i = pat_cafe;
    bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'hA00;
    for (int c = 1; c <= 16; c++) begin
      step();
      #1;
      chk1("edge_enable", bus.mem_enable_o, 1'b1);
      chk1("edge_p1_ack", bus.p1_ack_o, (c == 16));
      if (c == 1) chk32("edge_addr", bus.mem_addr_o, 32'hA00);
      if (c == 16) chk256("edge_rd_data", bus.rd_data_o, pat_cafe);
    end
    step();
    bus.p1_enable_i = 1'b0;
    #1;
    chk1("edge_enable_low", bus.mem_enable_o, 1'b0);
    chk1("edge_err_low", err, 1'b0);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
